mx_negator_arbiter: RTL and testbench
=====================================

Name: mx_negator_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one MXINT8 vector negation datapath (mx_vector_negator) among NUM_REQ requesters.
- Each request carries a t_mxint8_vector and an op bit (negate or pass-through). The block grants one request per cycle and registers the result into a single-entry output stage with valid/ready backpressure.
- Sits in front of the MX ALU accumulate stage, so the subtract paths of several lanes can reuse one negator.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(NUM_REQ), width of the requester index.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_vector  input  NUM_REQ x $bits(t_mxint8_vector)  per-requester operand: E8M0 scale plus SCALING_BLOCK_SIZE INT8 elements.
- req_neg  input  NUM_REQ  per-requester op: 1 = negate elements, 0 = pass through.
- rsp_valid  output  1  output register holds a result.
- rsp_ready  input  1  downstream accepts the result.
- rsp_vector  output  $bits(t_mxint8_vector)  result vector.
- rsp_id  output  ID_W  index of the requester that produced rsp_vector.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - rsp_valid=0, rsp_vector=0, rsp_id=0.
  - Round-robin pointer rr_ptr=0; state=EMPTY.
  - req_ready is forced to all zeros while rst=1.
- State machine, two states:
  - EMPTY: output register has no valid data.
  - FULL: output register holds valid data.
- can_accept = (state==EMPTY) | (rsp_valid & rsp_ready).
- Arbitration (combinational):
  - Among the asserted req_valid bits, grant the first index at or after rr_ptr, searching upward and wrapping modulo NUM_REQ.
  - req_ready[g] = can_accept & req_valid[g]; all other req_ready bits are 0.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
  - A requester must hold valid, vector and op stable until it is accepted.
- On accept (a req_valid[g] & req_ready[g] handshake):
  - The selected vector is driven through the single negator instance.
  - rsp_vector is loaded with the negator output if req_neg[g]=1, otherwise with the selected vector unchanged.
  - rsp_id is loaded with g; rsp_valid=1; state=FULL.
  - rr_ptr becomes (g+1) mod NUM_REQ.
- Latency and throughput: one cycle from handshake to rsp_valid. Throughput is one result per cycle while rsp_ready=1.
- Drain with no new grant (rsp_valid & rsp_ready and no req_valid): rsp_valid=0, state=EMPTY, rr_ptr unchanged.
- Simultaneous drain and grant: the output register is overwritten in the same edge and stays FULL. No bubble is inserted.
- Backpressure (FULL & !rsp_ready):
  - rsp_vector and rsp_id stay stable.
  - All req_ready bits are 0 and rr_ptr is frozen.
- Arithmetic:
  - Negation is element-wise 8-bit two's complement, computed modulo 256. 0x00 maps to 0x00 and 0x80 maps to 0x80.
  - The scale is always passed unchanged, including the NaN scale 0xFF.
- No requests valid: no grant and no state change.
- Reset asserted mid-operation: any held response is discarded without handshake. After reset release, arbitration restarts at index 0.

Optional Feature:
- Macro: MX_NEG_ARB_SAT_EN.
- Defined: on a negate op, any element equal to 0x80 (-128) yields 0x7F (+127), i.e. symmetric saturation. The replacement is applied after the negator, before the output register. Latency is unchanged and pass-through ops are unaffected.
- Undefined: pure wrap-around, so 0x80 yields 0x80. No saturation logic is present.

Test Plan:
1. Reset behaviour: assert rst mid-cycle while rsp_valid=1 -> rsp_valid, rsp_id and req_ready all 0 immediately. After release, a lone request from requester 2 is granted and rsp_id=2.
2. Single negate, NUM_REQ=4: req 0 with scale=0x7F, all elements 0x05, neg=1 -> next cycle rsp_valid=1, elements 0xFB, scale 0x7F, rsp_id=0. The same vector with neg=0 -> elements 0x05.
3. Fairness: all four requesters valid continuously, rsp_ready=1 -> grants and rsp_id sequence 0,1,2,3,0,1 on consecutive cycles, one result per cycle.
4. Backpressure: rsp_ready=0 for 3 cycles with all requesters valid -> rsp_vector and rsp_id stable, req_ready=0000, rr_ptr unchanged. When rsp_ready rises, the drain and the next grant occur in the same cycle.
5. Boundary elements: elements {0x80, 0x00, 0x7F, 0x01}, scale 0xFF, neg=1 -> {0x80, 0x00, 0x81, 0xFF} and scale 0xFF. With MX_NEG_ARB_SAT_EN defined, the first element becomes 0x7F instead.
6. Sparse and wrap: only requesters 3 and 1 valid with rr_ptr=2 -> requester 3 is granted first, then requester 1 (pointer wraps through 0). An idle cycle with no valid requests leaves rr_ptr=2.

Source files
------------

// File: rtl/mx_negator_arbiter.sv
// mx_negator_arbiter: round-robin arbiter that shares one MXINT8 vector
// negator among NUM_REQ requesters, with a single-entry valid/ready output stage.
// Optional build macro: MX_NEG_ARB_SAT_EN (negating 0x80 saturates to 0x7F).

package mx_pkg;
   localparam int unsigned SCALING_BLOCK_SIZE = 4;

   typedef struct packed {
      logic [7:0]                         scale;
      logic [SCALING_BLOCK_SIZE-1:0][7:0] elem;
   } t_mxint8_vector;
endpackage

// mx_vector_negator: element-wise two's complement negation, scale untouched.
module mx_vector_negator
   import mx_pkg::*;
(
   input  t_mxint8_vector vec_i,
   output t_mxint8_vector vec_o
);

   // Negate every INT8 element modulo 256; the E8M0 scale (incl. NaN 0xFF) passes through
   always_comb begin
      vec_o.scale = vec_i.scale;
      vec_o.elem  = '0;
      for (int unsigned k = 0; k < SCALING_BLOCK_SIZE; k++) begin
         vec_o.elem[k] = 8'd0 - vec_i.elem[k];
      end
   end

endmodule

module mx_negator_arbiter
   import mx_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic           [NUM_REQ-1:0]  req_valid,
   output logic           [NUM_REQ-1:0]  req_ready,
   input  t_mxint8_vector [NUM_REQ-1:0]  req_vector,
   input  logic           [NUM_REQ-1:0]  req_neg,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output t_mxint8_vector                rsp_vector,
   output logic           [ID_W-1:0]     rsp_id
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t          state_q;
   logic            rsp_valid_q;
   t_mxint8_vector  rsp_vector_q;
   t_mxint8_vector  rsp_vector_d;
   logic [ID_W-1:0] rsp_id_q;
   logic [ID_W-1:0] rr_ptr_q;
   logic [ID_W-1:0] rr_ptr_d;

   logic            gnt_found;
   logic [ID_W-1:0] gnt_idx;
   logic [ID_W-1:0] cand_idx;
   int unsigned     cand;
   logic            can_accept;
   logic            accept;

   t_mxint8_vector  sel_vec;
   t_mxint8_vector  neg_vec;

   // Round-robin search: first valid index at or after rr_ptr, wrapping modulo NUM_REQ
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand     = (32'(rr_ptr_q) + i) % NUM_REQ;
         cand_idx = ID_W'(cand);
         if (!gnt_found && req_valid[cand_idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand_idx;
         end
      end
   end

   assign can_accept = (state_q == EMPTY) | (rsp_valid_q & rsp_ready);
   assign accept     = can_accept & gnt_found;
   assign rr_ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

   // One-hot accept to the granted requester; held low throughout reset
   always_comb begin
      req_ready = '0;
      if (!rst && accept) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   assign sel_vec = req_vector[gnt_idx];

   mx_vector_negator u_negator (
      .vec_i (sel_vec),
      .vec_o (neg_vec)
   );

   // Choose negated or pass-through operand for the output register
   always_comb begin
      rsp_vector_d = req_neg[gnt_idx] ? neg_vec : sel_vec;
`ifdef MX_NEG_ARB_SAT_EN
      if (req_neg[gnt_idx]) begin
         for (int unsigned k = 0; k < SCALING_BLOCK_SIZE; k++) begin
            if (neg_vec.elem[k] == 8'h80) begin
               rsp_vector_d.elem[k] = 8'h7F;
            end
         end
      end
`endif
   end

   // Output-stage FSM: load on accept (also when draining), empty on drain without grant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= EMPTY;
         rsp_valid_q  <= 1'b0;
         rsp_vector_q <= '0;
         rsp_id_q     <= '0;
         rr_ptr_q     <= '0;
      end else begin
         if (accept) begin
            state_q      <= FULL;
            rsp_valid_q  <= 1'b1;
            rsp_vector_q <= rsp_vector_d;
            rsp_id_q     <= gnt_idx;
            rr_ptr_q     <= rr_ptr_d;
         end else if (rsp_valid_q && rsp_ready) begin
            state_q     <= EMPTY;
            rsp_valid_q <= 1'b0;
         end
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_vector = rsp_vector_q;
   assign rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_mx_negator_arbiter.sv
// Directed testbench for mx_negator_arbiter (NUM_REQ=4, 4-element MXINT8 vectors).
module tb_mx_negator_arbiter;
   import mx_pkg::*;

   logic                 clk;
   logic                 rst;
   logic [3:0]           req_valid;
   logic [3:0]           req_ready;
   t_mxint8_vector [3:0] req_vector;
   logic [3:0]           req_neg;
   logic                 rsp_valid;
   logic                 rsp_ready;
   t_mxint8_vector       rsp_vector;
   logic [1:0]           rsp_id;

   int total = 0;
   int bad   = 0;

   t_mxint8_vector e0n, e0p, e1p, e2n, e3n, v3;
   t_mxint8_vector exp_by_id [4];
   int unsigned    fair_ids [6];

   mx_negator_arbiter #(.NUM_REQ(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_vector (req_vector),
      .req_neg    (req_neg),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_vector (rsp_vector),
      .rsp_id     (rsp_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic t_mxint8_vector mk(input logic [7:0] s, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] c,
                                         input logic [7:0] d);
      t_mxint8_vector v;
      v.scale   = s;
      v.elem[0] = a;
      v.elem[1] = b;
      v.elem[2] = c;
      v.elem[3] = d;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rsp(input string tag, input logic v, input logic [1:0] id,
                          input t_mxint8_vector vec);
      chk({tag, "_valid"}, 64'(rsp_valid), 64'(v));
      chk({tag, "_id"}, 64'(rsp_id), 64'(id));
      chk({tag, "_vec"}, 64'(rsp_vector), 64'(vec));
   endtask

   initial begin
      // Hand-computed expected results
      e0n = mk(8'h7F, 8'hFB, 8'hFB, 8'hFB, 8'hFB);
      e0p = mk(8'h7F, 8'h05, 8'h05, 8'h05, 8'h05);
      e1p = mk(8'h01, 8'h11, 8'h22, 8'h33, 8'h44);
      e2n = mk(8'h02, 8'hFF, 8'hFE, 8'hFD, 8'hFC);
`ifdef MX_NEG_ARB_SAT_EN
      e3n = mk(8'hFF, 8'h7F, 8'h00, 8'h81, 8'hFF);
`else
      e3n = mk(8'hFF, 8'h80, 8'h00, 8'h81, 8'hFF);
`endif
      v3  = mk(8'hFF, 8'h80, 8'h00, 8'h7F, 8'h01);
      exp_by_id[0] = e0n;
      exp_by_id[1] = e1p;
      exp_by_id[2] = e2n;
      exp_by_id[3] = e3n;
      fair_ids[0] = 0; fair_ids[1] = 1; fair_ids[2] = 2;
      fair_ids[3] = 3; fair_ids[4] = 0; fair_ids[5] = 1;

      // Operands
      req_vector[0] = mk(8'h7F, 8'h05, 8'h05, 8'h05, 8'h05);
      req_vector[1] = mk(8'h01, 8'h11, 8'h22, 8'h33, 8'h44);
      req_vector[2] = mk(8'h02, 8'h01, 8'h02, 8'h03, 8'h04);
      req_vector[3] = v3;
      req_neg       = 4'b1101;
      req_valid     = 4'b1111;
      rsp_ready     = 1'b1;
      rst           = 1'b1;

      // Reset state, req_ready forced low even with requests pending
      tick();
      chk_rsp("rst", 1'b0, 2'd0, '0);
      chk("rst_ready", 64'(req_ready), 64'(4'b0000));
      req_valid = 4'b0000;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("idle_ready", 64'(req_ready), 64'(4'b0000));
      tick();
      chk("idle_valid", 64'(rsp_valid), 64'(1'b0));

      // Single negate from requester 0, then pass-through
      req_valid = 4'b0001;
      #1;
      chk("neg0_ready", 64'(req_ready), 64'(4'b0001));
      tick();
      req_valid = 4'b0000;
      chk_rsp("neg0", 1'b1, 2'd0, e0n);
      req_neg[0] = 1'b0;
      req_valid  = 4'b0001;
      #1;
      chk("pass0_ready", 64'(req_ready), 64'(4'b0001));
      tick();
      req_valid  = 4'b0000;
      req_neg[0] = 1'b1;
      chk_rsp("pass0", 1'b1, 2'd0, e0p);
      tick();
      chk("drain_valid", 64'(rsp_valid), 64'(1'b0));

      // Mid-operation reset discards a held response
      req_valid = 4'b0010;
      rsp_ready = 1'b0;
      #1;
      chk("hold1_ready", 64'(req_ready), 64'(4'b0010));
      tick();
      req_valid = 4'b0100;
      #1;
      chk("full_ready", 64'(req_ready), 64'(4'b0000));
      chk_rsp("hold1", 1'b1, 2'd1, e1p);
      #1;
      rst = 1'b1;
      #1;
      chk_rsp("midrst", 1'b0, 2'd0, '0);
      chk("midrst_ready", 64'(req_ready), 64'(4'b0000));
      @(negedge clk);
      rst       = 1'b0;
      rsp_ready = 1'b1;
      #1;
      chk("post_rst_ready", 64'(req_ready), 64'(4'b0100));
      tick();
      req_valid = 4'b0000;
      chk_rsp("post_rst", 1'b1, 2'd2, e2n);

      // Boundary elements and NaN scale from requester 3
      req_valid = 4'b1000;
      #1;
      chk("bound_ready", 64'(req_ready), 64'(4'b1000));
      tick();
      req_valid = 4'b0000;
      chk_rsp("bound", 1'b1, 2'd3, e3n);

      // Fairness: all requesters valid, one result per cycle
      req_valid = 4'b1111;
      #1;
      chk("fair_ready0", 64'(req_ready), 64'(4'b0001));
      for (int k = 0; k < 6; k++) begin
         tick();
         chk_rsp("fair", 1'b1, 2'(fair_ids[k]), exp_by_id[fair_ids[k]]);
         chk("fair_ready", 64'(req_ready), 64'(4'b0001 << ((fair_ids[k] + 1) % 4)));
      end

      // Backpressure: output stable, no grants, pointer frozen
      rsp_ready = 1'b0;
      #1;
      chk("bp_ready0", 64'(req_ready), 64'(4'b0000));
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_rsp("bp", 1'b1, 2'd1, e1p);
         chk("bp_ready", 64'(req_ready), 64'(4'b0000));
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready", 64'(req_ready), 64'(4'b0100));
      tick();
      chk_rsp("bp_release", 1'b1, 2'd2, e2n);

      // Sparse requests with wrap; an idle gap must not move the pointer
      req_valid = 4'b0010;
      #1;
      chk("sp_set_ready", 64'(req_ready), 64'(4'b0010));
      tick();
      req_valid = 4'b0000;
      chk_rsp("sp_set", 1'b1, 2'd1, e1p);
      tick();
      chk("sp_drain", 64'(rsp_valid), 64'(1'b0));
      tick();
      chk("sp_idle", 64'(rsp_valid), 64'(1'b0));
      req_valid = 4'b1010;
      #1;
      chk("sp_ready3", 64'(req_ready), 64'(4'b1000));
      tick();
      req_valid = 4'b0010;
      #1;
      chk_rsp("sp3", 1'b1, 2'd3, e3n);
      chk("sp_ready1", 64'(req_ready), 64'(4'b0010));
      tick();
      req_valid = 4'b0000;
      chk_rsp("sp1", 1'b1, 2'd1, e1p);
      tick();
      chk("sp_end", 64'(rsp_valid), 64'(1'b0));

      // Pass-through keeps 0x80 untouched regardless of saturation build
      req_neg[3] = 1'b0;
      req_valid  = 4'b1000;
      #1;
      chk("pass3_ready", 64'(req_ready), 64'(4'b1000));
      tick();
      req_valid = 4'b0000;
      chk_rsp("pass3", 1'b1, 2'd3, v3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
